// File: rtl/branch_target_buffer_pkg.sv
// Shared geometry, entry layout and PC field positions for the 2-way branch target buffer.
package branch_target_buffer_pkg;

    localparam int BTB_SETS  = 16;
    localparam int BTB_WAYS  = 2;
    localparam int TAG_BITS  = 10;
    localparam int IDX_BITS  = $clog2(BTB_SETS);
    localparam int ADDR_BITS = 32;
    localparam int NUM_SLOTS = 4;

    localparam int IDX_LSB = 2;
    localparam int IDX_MSB = IDX_BITS + 1;
    localparam int TAG_LSB = IDX_BITS + 2;
    localparam int TAG_MSB = IDX_BITS + TAG_BITS + 1;

    typedef logic [IDX_BITS-1:0]  btb_idx_t;
    typedef logic [TAG_BITS-1:0]  btb_tag_t;
    typedef logic [ADDR_BITS-1:0] btb_addr_t;

    typedef struct packed {
        logic      valid;
        btb_tag_t  tag;
        btb_addr_t target;
    } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_set_lookup.sv
// Combinational 2-way tag compare of one PC tag against both ways of a single set.
module btb_set_lookup
    import branch_target_buffer_pkg::*;
(
    input  btb_tag_t   tag,
    input  btb_entry_t way0,
    input  btb_entry_t way1,
    output logic       hit,
    output logic       hit_way,
    output btb_addr_t  target
);

    logic match0;
    logic match1;

    assign match0 = way0.valid && (way0.tag == tag);
    assign match1 = way1.valid && (way1.tag == tag);

    // Install dedups, so at most one way can match; way 0 wins only as a tie-break.
    always_comb begin
        hit     = match0 | match1;
        hit_way = 1'b0;
        target  = '0;
        if (match0) begin
            target = way0.target;
        end else if (match1) begin
            hit_way = 1'b1;
            target  = way1.target;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Fetch-side 2-way set-associative BTB: NUM_SLOTS zero-latency read ports, one install/update port.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_SLOTS-1:0][ADDR_BITS-1:0]  PCs_out,
    output logic [NUM_SLOTS-1:0]                 btb_hit,
    output logic [NUM_SLOTS-1:0][ADDR_BITS-1:0]  btb_targets,
    input  logic                                 resolving_valid_branch,
    input  logic [ADDR_BITS-1:0]                 resolve_pc,
    input  logic [ADDR_BITS-1:0]                 resolve_target,
    input  logic                                 taken
);

    btb_entry_t          entries_w0 [BTB_SETS];
    btb_entry_t          entries_w1 [BTB_SETS];
    logic [BTB_SETS-1:0] lru;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_read
        btb_idx_t  idx;
        btb_tag_t  tag;
        logic      hit;
        logic      hit_way_unused;
        btb_addr_t target;
        logic      pc_unused;

        assign idx = PCs_out[s][IDX_MSB:IDX_LSB];
        assign tag = PCs_out[s][TAG_MSB:TAG_LSB];

        btb_set_lookup u_lookup (
            .tag     (tag),
            .way0    (entries_w0[idx]),
            .way1    (entries_w1[idx]),
            .hit     (hit),
            .hit_way (hit_way_unused),
            .target  (target)
        );

        // Outputs are forced quiet while reset is held, whatever the array holds.
        assign btb_hit[s]     = hit & ~reset;
        assign btb_targets[s] = reset ? '0 : target;

        assign pc_unused = ^{PCs_out[s][ADDR_BITS-1:TAG_MSB+1], PCs_out[s][1:0], hit_way_unused};
    end

    btb_idx_t  upd_idx;
    btb_tag_t  upd_tag;
    logic      upd_en;
    logic      upd_hit;
    logic      upd_way;
    btb_addr_t upd_target_unused;
    logic      victim;
    logic      resolve_unused;

    assign upd_idx = resolve_pc[IDX_MSB:IDX_LSB];
    assign upd_tag = resolve_pc[TAG_MSB:TAG_LSB];
    assign upd_en  = resolving_valid_branch & taken;

    btb_set_lookup u_update_lookup (
        .tag     (upd_tag),
        .way0    (entries_w0[upd_idx]),
        .way1    (entries_w1[upd_idx]),
        .hit     (upd_hit),
        .hit_way (upd_way),
        .target  (upd_target_unused)
    );

    assign resolve_unused = ^{resolve_pc[ADDR_BITS-1:TAG_MSB+1], resolve_pc[1:0], upd_target_unused};

    // Refresh in place on a hit; otherwise fill way 0, then way 1, then evict the LRU way.
    always_comb begin
        victim = lru[upd_idx];
        if (upd_hit) begin
            victim = upd_way;
        end else if (!entries_w0[upd_idx].valid) begin
            victim = 1'b0;
        end else if (!entries_w1[upd_idx].valid) begin
            victim = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < BTB_SETS; s++) begin
                entries_w0[s] <= '0;
                entries_w1[s] <= '0;
            end
            lru <= '0;
        end else if (upd_en) begin
            if (victim) begin
                entries_w1[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: resolve_target};
            end else begin
                entries_w0[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: resolve_target};
            end
            lru[upd_idx] <= ~victim;
        end
    end

endmodule
